// File: rtl/ppt_pkg.sv
// Shared definitions for the PPT pulse sequencer and the register block that configures it.
package ppt_pkg;

    localparam int CNT_W = 16;
    localparam int DIV_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } ppt_state_t;

    // Power-on register values: 32.768 kHz / 2^10 = 32 Hz tick, one-tick pulse every 4 s.
    localparam logic [DIV_W-1:0] CLK_DIV = 5'd9;
    localparam logic [CNT_W-1:0] PERIOD  = 16'd128;
    localparam logic [CNT_W-1:0] WIDTH   = 16'd1;
    localparam logic [CNT_W-1:0] COUNT   = 16'd16;

endpackage

// File: rtl/ppt_prescaler.sv
// Free-running 32-bit prescaler; tick pulses once every 2^(clk_div+1) clocks after a clear.
module ppt_prescaler
    import ppt_pkg::*;
#(
    parameter int DIV_W_P = DIV_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic [DIV_W_P-1:0] clk_div,
    output logic               tick
);

    logic [31:0] cnt;
    logic [32:0] mask_wide;
    logic [31:0] mask;

    // A 33-bit shift keeps clk_div=31 (full 32-bit mask) from overflowing.
    assign mask_wide = (33'd1 << ({1'b0, clk_div} + 1'b1)) - 33'd1;
    assign mask      = mask_wide[31:0];
    assign tick      = ((cnt & mask) == mask);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ppt_pulse_sequencer.sv
// PPT firing-line sequencer: count pulses of width ticks every period ticks.
// Optional macro PPT_CONTINUOUS_MODE_EN makes count==0 fire until run_ppt falls.
module ppt_pulse_sequencer
    import ppt_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] count,
    input  logic             run_ppt,
    output logic [CNT_W-1:0] count_done,
    output logic             done,
    output logic             ppt_out,
    output logic             busy
);

    ppt_state_t       state;
    logic             run_q;
    logic             run_armed;
    logic [DIV_W-1:0] div_s;
    logic [CNT_W-1:0] period_s;
    logic [CNT_W-1:0] width_s;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W-1:0] t;

    logic             tick;
    logic             start_ok;
    logic             start_to_done;
    logic             wrap_ok;
    logic [CNT_W-1:0] period_eff;
    logic [CNT_W-1:0] t_inc;
    logic             period_end;
    logic             last_pulse;
    logic [CNT_W-1:0] cd_next;

    // run_armed blocks a start when run_ppt is already high as reset releases.
    assign start_ok   = run_ppt && !run_q && run_armed && (state == IDLE || state == DONE);
    assign period_eff = (period_s == '0) ? CNT_W'(1) : period_s;
    assign t_inc      = t + CNT_W'(1);
    assign period_end = (t_inc == period_eff);
    assign last_pulse = (count_s != '0) && (count_done == count_s - CNT_W'(1));
    assign cd_next    = (count_done == '1 && !wrap_ok) ? count_done : count_done + CNT_W'(1);

`ifdef PPT_CONTINUOUS_MODE_EN
    assign start_to_done = 1'b0;
    assign wrap_ok       = (count_s == '0);
`else
    assign start_to_done = (count == '0);
    assign wrap_ok       = 1'b0;
`endif

    ppt_prescaler #(
        .DIV_W_P (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (start_ok),
        .clk_div (div_s),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            run_q      <= 1'b0;
            run_armed  <= 1'b0;
            div_s      <= '0;
            period_s   <= '0;
            width_s    <= '0;
            count_s    <= '0;
            t          <= '0;
            count_done <= '0;
            done       <= 1'b0;
            ppt_out    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            run_q <= run_ppt;
            if (!run_ppt) begin
                run_armed <= 1'b1;
            end

            if (start_ok) begin
                div_s      <= clk_div;
                period_s   <= period;
                width_s    <= width;
                count_s    <= count;
                t          <= '0;
                count_done <= '0;
                if (start_to_done) begin
                    state   <= DONE;
                    done    <= 1'b1;
                    ppt_out <= 1'b0;
                    busy    <= 1'b0;
                end else begin
                    state   <= (width == '0) ? LOW : HIGH;
                    done    <= 1'b0;
                    ppt_out <= (width != '0);
                    busy    <= 1'b1;
                end
            end else begin
                case (state)
                    HIGH, LOW: begin
                        if (!run_ppt) begin
                            state   <= IDLE;
                            ppt_out <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b0;
                        end else if (tick) begin
                            // Period end is checked first so width>=period holds the line high.
                            if (period_end) begin
                                t          <= '0;
                                count_done <= cd_next;
                                if (last_pulse) begin
                                    state   <= DONE;
                                    done    <= 1'b1;
                                    ppt_out <= 1'b0;
                                    busy    <= 1'b0;
                                end else begin
                                    state   <= (width_s == '0) ? LOW : HIGH;
                                    ppt_out <= (width_s != '0);
                                end
                            end else if (state == HIGH && t_inc == width_s) begin
                                t       <= t_inc;
                                state   <= LOW;
                                ppt_out <= 1'b0;
                            end else begin
                                t <= t_inc;
                            end
                        end
                    end
                    DONE: begin
                        if (!run_ppt) begin
                            state <= IDLE;
                            done  <= 1'b0;
                        end
                    end
                    default: begin
                        ppt_out <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppt_pulse_sequencer.sv
// Self-checking bench for ppt_pulse_sequencer: constant vector table, closed-form model, corner sequences.
module tb_ppt_pulse_sequencer;
    import ppt_pkg::*;

    logic             clk = 1'b0;
    logic             rstn;
    logic [DIV_W-1:0] clk_div;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] count;
    logic             run_ppt;
    logic [CNT_W-1:0] count_done;
    logic             done;
    logic             ppt_out;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string name;
        int    div;
        int    per;
        int    wid;
        int    cnt;
        int    m;
        bit    ep;
        bit    ed;
        bit    eb;
        int    ecd;
    } vec_t;

    vec_t tbl[$];

    ppt_pulse_sequencer dut (
        .clk        (clk),
        .rstn       (rstn),
        .clk_div    (clk_div),
        .period     (period),
        .width      (width),
        .count      (count),
        .run_ppt    (run_ppt),
        .count_done (count_done),
        .done       (done),
        .ppt_out    (ppt_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Closed form: after m clocks, n = m / 2^(div+1) ticks, pulses = n / period, phase = n % period.
    function automatic void model(input int d, input int p, input int w, input int c, input int m,
                                  output bit ep, output bit ed, output bit eb, output int ecd);
        longint ps, n, pe, pulses, phase;
        bit     cont;
        ps     = longint'(1) << (d + 1);
        n      = longint'(m) / ps;
        pe     = (p == 0) ? 1 : longint'(p);
        pulses = n / pe;
        phase  = n % pe;
        cont   = 1'b0;
`ifdef PPT_CONTINUOUS_MODE_EN
        cont = (c == 0);
`endif
        if (!cont && pulses >= longint'(c)) begin
            ep = 1'b0; ed = 1'b1; eb = 1'b0; ecd = c;
        end else begin
            ep = (phase < longint'(w)); ed = 1'b0; eb = 1'b1; ecd = int'(pulses % 65536);
        end
    endfunction

    task automatic checkOutput(input string name, input int m, input bit ep, input bit ed,
                               input bit eb, input int ecd);
        vectors++;
        if (ppt_out !== ep || done !== ed || busy !== eb || count_done !== 16'(ecd)) begin
            miscompares++;
            $display("[TB] FAIL %s m=%0d: got ppt_out=%0b done=%0b busy=%0b count_done=%0d, expected ppt_out=%0b done=%0b busy=%0b count_done=%0d",
                     name, m, ppt_out, done, busy, count_done, ep, ed, eb, ecd);
        end
    endtask

    task automatic applyStimulus(input int d, input int p, input int w, input int c);
        clk_div = DIV_W'(d);
        period  = CNT_W'(p);
        width   = CNT_W'(w);
        count   = CNT_W'(c);
        run_ppt = 1'b1;
    endtask

    task automatic idleGap();
        run_ppt = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic checkModelRun(input string name, input int d, input int p, input int w,
                                 input int c, input int ncycles);
        bit ep, ed, eb;
        int ecd;
        applyStimulus(d, p, w, c);
        for (int m = 0; m < ncycles; m++) begin
            @(negedge clk);
            model(d, p, w, c, m, ep, ed, eb, ecd);
            checkOutput(name, m, ep, ed, eb, ecd);
        end
    endtask

    // Drop run after cycle a-1; the next edge must land in IDLE with count_done frozen.
    task automatic dropAndCheckAbort(input string name, input int d, input int p, input int w,
                                     input int c, input int a);
        bit ep, ed, eb;
        int ecd;
        model(d, p, w, c, a - 1, ep, ed, eb, ecd);
        run_ppt = 1'b0;
        @(negedge clk);
        checkOutput(name, a, 1'b0, 1'b0, 1'b0, ecd);
    endtask

    initial begin
        bit ep, ed, eb;
        int ecd;

        tbl.push_back('{"t1_first_high",  0, 4, 1, 3,  0, 1'b1, 1'b0, 1'b1, 0});
        tbl.push_back('{"t1_first_low",   0, 4, 1, 3,  2, 1'b0, 1'b0, 1'b1, 0});
        tbl.push_back('{"t1_second_high", 0, 4, 1, 3,  8, 1'b1, 1'b0, 1'b1, 1});
        tbl.push_back('{"t1_last_low",    0, 4, 1, 3, 23, 1'b0, 1'b0, 1'b1, 2});
        tbl.push_back('{"t1_done",        0, 4, 1, 3, 24, 1'b0, 1'b1, 1'b0, 3});
        tbl.push_back('{"wide_high",      0, 4, 6, 2, 15, 1'b1, 1'b0, 1'b1, 1});
        tbl.push_back('{"wide_done",      0, 4, 6, 2, 16, 1'b0, 1'b1, 1'b0, 2});
        tbl.push_back('{"div1_high",      1, 3, 2, 2,  4, 1'b1, 1'b0, 1'b1, 0});
        tbl.push_back('{"div1_low",       1, 3, 2, 2,  8, 1'b0, 1'b0, 1'b1, 0});
        tbl.push_back('{"div1_pulse2",    1, 3, 2, 2, 12, 1'b1, 1'b0, 1'b1, 1});
        tbl.push_back('{"div1_done",      1, 3, 2, 2, 24, 1'b0, 1'b1, 1'b0, 2});
        tbl.push_back('{"p0_w0_run",      0, 0, 0, 3,  5, 1'b0, 1'b0, 1'b1, 2});
        tbl.push_back('{"p0_w0_done",     0, 0, 0, 3,  6, 1'b0, 1'b1, 1'b0, 3});
`ifdef PPT_CONTINUOUS_MODE_EN
        tbl.push_back('{"count0_cont",    0, 4, 1, 0,  0, 1'b1, 1'b0, 1'b1, 0});
`else
        tbl.push_back('{"count0_done",    0, 4, 1, 0,  0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{"count0_nofire",  0, 4, 1, 0,  9, 1'b0, 1'b1, 1'b0, 0});
`endif

        rstn    = 1'b0;
        run_ppt = 1'b0;
        clk_div = CLK_DIV;
        period  = PERIOD;
        width   = WIDTH;
        count   = COUNT;
        repeat (3) @(negedge clk);
        checkOutput("reset", 0, 1'b0, 1'b0, 1'b0, 0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_idle", 0, 1'b0, 1'b0, 1'b0, 0);

        foreach (tbl[i]) begin
            idleGap();
            applyStimulus(tbl[i].div, tbl[i].per, tbl[i].wid, tbl[i].cnt);
            repeat (tbl[i].m + 1) @(negedge clk);
            checkOutput(tbl[i].name, tbl[i].m, tbl[i].ep, tbl[i].ed, tbl[i].eb, tbl[i].ecd);
        end

        // Abort after the second pulse completes.
        idleGap();
        checkModelRun("abort_run", 0, 4, 1, 5, 17);
        dropAndCheckAbort("abort", 0, 4, 1, 5, 17);
        @(negedge clk);
        checkOutput("abort_hold", 18, 1'b0, 1'b0, 1'b0, 2);

        // Mid-run config changes are ignored until the next start.
        idleGap();
        applyStimulus(0, 4, 1, 2);
        for (int m = 0; m <= 16; m++) begin
            @(negedge clk);
            model(0, 4, 1, 2, m, ep, ed, eb, ecd);
            checkOutput("midchange", m, ep, ed, eb, ecd);
            if (m == 3) begin
                period = 16'd3;
                count  = 16'd7;
            end
        end
        run_ppt = 1'b0;
        @(negedge clk);
        checkOutput("done_to_idle", 17, 1'b0, 1'b0, 1'b0, 2);
        @(negedge clk);
        checkModelRun("rearm_new_cfg", 0, 3, 1, 7, 44);

        // Async reset mid-pulse, then run held high must not restart.
        idleGap();
        applyStimulus(0, 4, 1, 3);
        repeat (9) @(negedge clk);
        checkOutput("rst_pre", 8, 1'b1, 1'b0, 1'b1, 1);
        #2 rstn = 1'b0;
        #1 checkOutput("rst_async", 8, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("rst_no_start", k, 1'b0, 1'b0, 1'b0, 0);
        end
        idleGap();
        checkModelRun("rst_restart", 0, 4, 1, 3, 26);

`ifdef PPT_CONTINUOUS_MODE_EN
        idleGap();
        checkModelRun("continuous", 0, 2, 1, 0, 440);
        dropAndCheckAbort("continuous_stop", 0, 2, 1, 0, 440);
`endif

        // Randomised configurations with a random abort point, checked every cycle.
        for (int r = 0; r < 24; r++) begin
            int d, p, w, c, total, a;
            d     = int'($urandom_range(0, 2));
            p     = int'($urandom_range(0, 6));
            w     = int'($urandom_range(0, 7));
            c     = int'($urandom_range(0, 5));
            total = (2 << d) * ((p == 0) ? 1 : p) * ((c == 0) ? 3 : c) + 6;
            a     = int'($urandom_range(1, total));
            idleGap();
            checkModelRun("random", d, p, w, c, a);
            dropAndCheckAbort("random_abort", d, p, w, c, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
